risc_control_unit: RTL and testbench

RISC_CONTROL_UNIT -- requirements
Module: risc_control_unit

---
 rtl/risc_control_unit.sv | 151 +++++++++++++++
 tb/tb_risc_control_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_control_unit.sv
// Multi-cycle control FSM for a small 8-bit RISC core: fetch, execute, memory, write-back.
// The ALU, register file and memories are outside; this block sequences them and owns PC/IR/flag.
module risc_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  alu_op,
  output logic        sel_imm,
  output logic [7:0]  imm,
  output logic [1:0]  rf_ra0,
  output logic [1:0]  rf_ra1,
  input  logic [7:0]  alu_out,
  input  logic        alu_zf,
  output logic        rf_we,
  output logic [1:0]  rf_wa,
  output logic [7:0]  rf_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  output logic [1:0]  state_o
);

  // state | meaning
  // FETCH | request imem at PC, wait for ack, latch instruction
  // EXEC  | present op to ALU, latch result, update flag / PC
  // MEM   | data-memory access at latched result, wait for ack
  // WB    | write result (or load data) to rd
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_WB = 2'd3} state_t;

  localparam logic [3:0] OP_CMP   = 4'd4;
  localparam logic [3:0] OP_CMPI  = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_JMPR  = 4'd11;
  localparam logic [3:0] OP_JNZ   = 4'd12;
  localparam logic [3:0] OP_LI    = 4'd13;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  result_q, result_d;
  logic        zflag_q, zflag_d;
  // Held low through reset and for the first cycle after, so imem_req restarts one cycle late.
  logic        run_q, run_d;

  logic [3:0]  op;
  logic [1:0]  rd, rs;
  logic [7:0]  pc_inc;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:10];
  assign rs     = ir_q[9:8];
  assign pc_inc = pc_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      result_q <= '0;
      zflag_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      result_q <= result_d;
      zflag_q  <= zflag_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    result_d = result_q;
    zflag_d  = zflag_q;
    run_d    = 1'b1;
    case (state_q)
      S_FETCH: begin
        if (run_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_out;
        if (op <= OP_CMPI) zflag_d = alu_zf;
        if (op <= OP_CMPI || op == OP_LI) begin
          state_d = S_WB;
        end else if (op == OP_LOAD || op == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
          if (op == OP_JMP || op == OP_JMPR) pc_d = alu_out;
          else if (op == OP_JNZ)             pc_d = zflag_q ? pc_inc : ir_q[7:0];
          else                               pc_d = pc_inc;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_STORE) begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
          end else begin
            result_d = dmem_rdata;
            state_d  = S_WB;
          end
        end
      end
      default: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
    endcase
  end

  // Operand routing depends only on the latched instruction, so it is stable in every state.
  always_comb begin
    imem_req  = (state_q == S_FETCH) && run_q;
    imem_addr = pc_q;
    alu_op    = (state_q == S_EXEC) ? op : 4'd0;
    imm       = ir_q[7:0];
    sel_imm   = 1'b1;
    rf_ra0    = rs;
    rf_ra1    = rd;
    if (op <= OP_CMP) begin
      sel_imm = 1'b0;
    end else if (op == OP_LOAD || op == OP_STORE) begin
      rf_ra1 = rs;
      if (op == OP_STORE) rf_ra0 = rd;
    end
    rf_we     = (state_q == S_WB);
    rf_wa     = rd;
    rf_wdata  = result_q;
    dmem_req  = (state_q == S_MEM);
    dmem_we   = (state_q == S_MEM) && (op == OP_STORE);
    dmem_addr = result_q;
    state_o   = state_q;
  end

endmodule

// File: tb/tb_risc_control_unit.sv
// Directed bench for risc_control_unit: behavioural ALU and register file around the DUT,
// instruction words and handshakes driven per scenario with hand-computed expectations.
module tb_risc_control_unit;

  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  alu_op;
  logic        sel_imm, alu_zf;
  logic [7:0]  imm, alu_out;
  logic [1:0]  rf_ra0, rf_ra1, rf_wa, state_o;
  logic        rf_we, dmem_req, dmem_we, dmem_ack;
  logic [7:0]  rf_wdata, dmem_addr, dmem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  logic [7:0] rf [4];

  risc_control_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_op(alu_op), .sel_imm(sel_imm), .imm(imm), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1),
    .alu_out(alu_out), .alu_zf(alu_zf),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wdata;
      wr_cnt    <= wr_cnt + 1;
    end
  end

  // Reference ALU: in0 = imm or R[ra0], in1 = R[ra1]; CMP yields 1 on equality.
  always_comb begin
    logic [7:0] in0, in1;
    in0 = sel_imm ? imm : rf[rf_ra0];
    in1 = rf[rf_ra1];
    case (alu_op)
      4'd0:                      alu_out = in0 & in1;
      4'd1:                      alu_out = in0 | in1;
      4'd2, 4'd5, 4'd8, 4'd9,
      4'd11:                     alu_out = in0 + in1;
      4'd3, 4'd6:                alu_out = in1 - in0;
      4'd4, 4'd7:                alu_out = (in0 == in1) ? 8'd1 : 8'd0;
      4'd10, 4'd12, 4'd13:       alu_out = in0;
      default:                   alu_out = 8'd0;
    endcase
    alu_zf = (alu_out == 8'd0);
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] im);
    return {op, rd, rs, im};
  endfunction

  // Waits (bounded) for a fetch request, acks it with ins, returns at the EXEC negedge.
  task automatic fetch_instr(input logic [15:0] ins);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_timeout: imem_req=%b after %0d cycles, required 1", imem_req, n);
    end
    imem_data = ins;
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 16'hE000;
  endtask

  task automatic exec_wb(input logic [15:0] ins);
    fetch_instr(ins);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({state_o, imem_req, dmem_req, dmem_we, rf_we} !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: st/ireq/dreq/dwe/we=%b required 000000",
               {state_o, imem_req, dmem_req, dmem_we, rf_we});
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_same_cycle: imem_req=%b required 0", imem_req);
    end
    @(negedge clk);
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_first_fetch: req/addr=%b/%h required 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_li;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({imem_req, imem_addr, state_o} !== {1'b1, 8'h00, 2'd0}) begin
        n_fail++;
        $display("FAIL fetch_wait_stable[%0d]: req/addr/st=%b/%h/%0d required 1/00/0",
                 i, imem_req, imem_addr, state_o);
      end
    end
    fetch_instr(enc(4'd13, 2'd1, 2'd0, 8'h05));
    n_tests++;
    if ({state_o, alu_op, sel_imm, imm, rf_we} !== {2'd1, 4'd13, 1'b1, 8'h05, 1'b0}) begin
      n_fail++;
      $display("FAIL li_exec: st/op/sel/imm/we=%0d/%0d/%b/%h/%b required 1/13/1/05/0",
               state_o, alu_op, sel_imm, imm, rf_we);
    end
    @(negedge clk);
    n_tests++;
    if ({state_o, rf_we, rf_wa, rf_wdata} !== {2'd3, 1'b1, 2'd1, 8'h05}) begin
      n_fail++;
      $display("FAIL li_wb: st/we/wa/wdata=%0d/%b/%0d/%h required 3/1/1/05",
               state_o, rf_we, rf_wa, rf_wdata);
    end
    @(negedge clk);
    n_tests++;
    if ({state_o, imem_req, imem_addr, rf_we} !== {2'd0, 1'b1, 8'h01, 1'b0}) begin
      n_fail++;
      $display("FAIL li_next_fetch: st/req/addr/we=%0d/%b/%h/%b required 0/1/01/0",
               state_o, imem_req, imem_addr, rf_we);
    end
  endtask

  task automatic test_cmp_jnz;
    exec_wb(enc(4'd13, 2'd2, 2'd0, 8'h05));
    fetch_instr(enc(4'd4, 2'd2, 2'd1, 8'h00));
    n_tests++;
    if ({alu_op, sel_imm, rf_ra0, rf_ra1} !== {4'd4, 1'b0, 2'd1, 2'd2}) begin
      n_fail++;
      $display("FAIL cmp_routing: op/sel/ra0/ra1=%0d/%b/%0d/%0d required 4/0/1/2",
               alu_op, sel_imm, rf_ra0, rf_ra1);
    end
    @(negedge clk);
    n_tests++;
    if ({rf_we, rf_wa, rf_wdata} !== {1'b1, 2'd2, 8'h01}) begin
      n_fail++;
      $display("FAIL cmp_wb: we/wa/wdata=%b/%0d/%h required 1/2/01", rf_we, rf_wa, rf_wdata);
    end
    @(negedge clk);
    n_tests++;
    if (imem_addr !== 8'h03) begin
      n_fail++;
      $display("FAIL cmp_next_pc: imem_addr=%h required 03", imem_addr);
    end
    fetch_instr(enc(4'd12, 2'd0, 2'd0, 8'h40));
    n_tests++;
    if ({state_o, alu_op, rf_we, dmem_req} !== {2'd1, 4'd12, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL jnz_exec: st/op/we/dreq=%0d/%0d/%b/%b required 1/12/0/0",
               state_o, alu_op, rf_we, dmem_req);
    end
    @(negedge clk);
    n_tests++;
    if ({state_o, imem_req, imem_addr} !== {2'd0, 1'b1, 8'h40}) begin
      n_fail++;
      $display("FAIL jnz_taken: st/req/addr=%0d/%b/%h required 0/1/40", state_o, imem_req, imem_addr);
    end
    exec_wb(enc(4'd3, 2'd1, 2'd1, 8'h00));
    fetch_instr(enc(4'd12, 2'd0, 2'd0, 8'h80));
    @(negedge clk);
    n_tests++;
    if ({state_o, imem_addr} !== {2'd0, 8'h42}) begin
      n_fail++;
      $display("FAIL jnz_not_taken: st/addr=%0d/%h required 0/42", state_o, imem_addr);
    end
  endtask

  task automatic test_load;
    exec_wb(enc(4'd13, 2'd3, 2'd0, 8'h20));
    fetch_instr(enc(4'd8, 2'd0, 2'd3, 8'h10));
    n_tests++;
    if ({sel_imm, rf_ra1, imm} !== {1'b1, 2'd3, 8'h10}) begin
      n_fail++;
      $display("FAIL load_routing: sel/ra1/imm=%b/%0d/%h required 1/3/10", sel_imm, rf_ra1, imm);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 8'h11;
    @(negedge clk);
    dmem_ack   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({state_o, dmem_req, dmem_we, dmem_addr, rf_we} !== {2'd2, 1'b1, 1'b0, 8'h30, 1'b0}) begin
        n_fail++;
        $display("FAIL load_mem_hold[%0d]: st/req/we/addr/rfwe=%0d/%b/%b/%h/%b required 2/1/0/30/0",
                 i, state_o, dmem_req, dmem_we, dmem_addr, rf_we);
      end
      if (i == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 8'hA5;
      end
      @(negedge clk);
    end
    dmem_ack   = 1'b0;
    dmem_rdata = 8'h5A;
    n_tests++;
    if ({state_o, rf_we, rf_wa, rf_wdata, dmem_req} !== {2'd3, 1'b1, 2'd0, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL load_wb: st/we/wa/wdata/dreq=%0d/%b/%0d/%h/%b required 3/1/0/a5/0",
               state_o, rf_we, rf_wa, rf_wdata, dmem_req);
    end
    @(negedge clk);
    n_tests++;
    if (imem_addr !== 8'h44) begin
      n_fail++;
      $display("FAIL load_next_pc: imem_addr=%h required 44", imem_addr);
    end
  endtask

  task automatic test_store;
    int w0;
    w0 = wr_cnt;
    fetch_instr(enc(4'd9, 2'd1, 2'd3, 8'h00));
    n_tests++;
    if ({sel_imm, rf_ra1, rf_ra0} !== {1'b1, 2'd3, 2'd1}) begin
      n_fail++;
      $display("FAIL store_routing: sel/ra1/ra0=%b/%0d/%0d required 1/3/1", sel_imm, rf_ra1, rf_ra0);
    end
    @(negedge clk);
    n_tests++;
    if ({state_o, dmem_req, dmem_we, dmem_addr, rf_ra0} !== {2'd2, 1'b1, 1'b1, 8'h20, 2'd1}) begin
      n_fail++;
      $display("FAIL store_mem: st/req/we/addr/ra0=%0d/%b/%b/%h/%0d required 2/1/1/20/1",
               state_o, dmem_req, dmem_we, dmem_addr, rf_ra0);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    n_tests++;
    if ({state_o, rf_we, dmem_req, imem_addr} !== {2'd0, 1'b0, 1'b0, 8'h45} || wr_cnt != w0) begin
      n_fail++;
      $display("FAIL store_done: st/we/dreq/addr=%0d/%b/%b/%h writes=%0d required 0/0/0/45 writes=0",
               state_o, rf_we, dmem_req, imem_addr, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_store;
    int w0;
    w0 = wr_cnt;
    fetch_instr(enc(4'd9, 2'd2, 2'd3, 8'h05));
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b1, 8'h25}) begin
        n_fail++;
        $display("FAIL store2_wait: req/we/addr=%b/%b/%h required 1/1/25", dmem_req, dmem_we, dmem_addr);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({state_o, dmem_req, dmem_we, rf_we, imem_req} !== {2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL store_reset: st/dreq/dwe/we/ireq=%0d/%b/%b/%b/%b required 0/0/0/0/0",
               state_o, dmem_req, dmem_we, rf_we, imem_req);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00} || wr_cnt != w0) begin
      n_fail++;
      $display("FAIL store_reset_restart: req/addr=%b/%h writes=%0d required 1/00 writes=0",
               imem_req, imem_addr, wr_cnt - w0);
    end
  endtask

  task automatic test_wrap_nop;
    fetch_instr(enc(4'd10, 2'd0, 2'd0, 8'hFF));
    @(negedge clk);
    n_tests++;
    if (imem_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL jmp_target: imem_addr=%h required ff", imem_addr);
    end
    exec_wb(enc(4'd2, 2'd0, 2'd0, 8'h00));
    n_tests++;
    if ({state_o, imem_addr} !== {2'd0, 8'h00}) begin
      n_fail++;
      $display("FAIL pc_wrap: st/addr=%0d/%h required 0/00", state_o, imem_addr);
    end
    fetch_instr(enc(4'd15, 2'd1, 2'd2, 8'h33));
    n_tests++;
    if ({state_o, rf_we, dmem_req, imem_req} !== {2'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL nop_exec: st/we/dreq/ireq=%0d/%b/%b/%b required 1/0/0/0",
               state_o, rf_we, dmem_req, imem_req);
    end
    @(negedge clk);
    n_tests++;
    if ({state_o, imem_req, imem_addr} !== {2'd0, 1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL nop_next_pc: st/req/addr=%0d/%b/%h required 0/1/01", state_o, imem_req, imem_addr);
    end
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_data  = 16'h0000;
    dmem_ack   = 1'b0;
    dmem_rdata = 8'h00;
    test_reset;
    test_li;
    test_cmp_jnz;
    test_load;
    test_store;
    test_reset_mid_store;
    test_wrap_nop;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
